muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request from the EX stage to begin an operation.
REQ-005 SHALL have port op, input, 2, operation: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 SHALL have port srcA, input, 32, EX-forwarded rs operand (multiplicand or dividend).
REQ-007 SHALL have port srcB, input, 32, EX-forwarded rt operand (multiplier or divisor).
REQ-008 SHALL have port flush, input, 1, pipeline flush: abort any in-flight operation.
REQ-009 SHALL have port busy, output, 1, operation in progress; the hazard logic stalls HI/LO readers while it is high.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking hi/lo updated.
REQ-011 SHALL have port hi, output, 32, HI result (product upper word or remainder).
REQ-012 SHALL have port lo, output, 32, LO result (product lower word or quotient).
REQ-013 SHALL have port div_by_zero, output, 1, pulses together with done when a divide had srcB=0.

Function
REQ-014 SHALL implement states IDLE, CALC and SIGN.
REQ-015 SHALL accept an operation only in IDLE, at a rising edge where start=1 and flush=0; srcA, srcB and op are captured at that edge.
REQ-016 SHALL ignore start while busy=1, and inputs SHALL not affect an in-flight operation.
REQ-017 SHALL, for signed ops, capture operand magnitudes and record the result signs at acceptance.
REQ-018 SHALL run CALC for exactly 32 cycles: one shift-add step per cycle for multiply, one restoring subtract-shift step per cycle for divide, with a 6-bit iteration counter.
REQ-019 SHALL apply sign correction in SIGN (1 cycle): the product is negated when operand signs differ; the quotient is negated when signs differ; the remainder takes the dividend's sign.
REQ-020 SHALL hold busy=1 for exactly 33 cycles after the accepting edge.
REQ-021 SHALL write hi/lo at the 33rd edge after acceptance and drive done=1 (and busy=0) in the following cycle.
REQ-022 SHALL accept a new start in the same cycle that done=1.
REQ-023 SHALL hold hi/lo constant except at the completion edge.
REQ-024 SHALL, on divide by zero, produce lo=0xFFFFFFFF and hi=srcA (unchanged dividend), and pulse div_by_zero with done.
REQ-025 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0 with no flag.
REQ-026 SHALL, when flush=1, return to IDLE at that edge with busy=0 next cycle, no done, and hi/lo unchanged; flush together with start SHALL not accept the start.

Reset
REQ-027 SHALL, on rst=1 at a rising edge, enter IDLE with busy=0, done=0, div_by_zero=0, hi=0, lo=0 and counter=0, including mid-operation; rst SHALL take priority over flush and start.

Configuration
REQ-028 SHALL, with macro MULDIV_DIV_EN defined, support all four ops as specified above.
REQ-029 SHALL, without MULDIV_DIV_EN, omit the divide datapath: start with op[1]=1 is not accepted (busy stays 0, no done, hi/lo unchanged) and div_by_zero is tied to 0.

Structure
REQ-030 SHALL take the op encodings, the state encoding and the constant MULDIV_ITERS=32 from shared package muldiv_pkg.
REQ-031 SHALL instantiate one sub-module, muldiv_signfix: a combinational conditional two's-complement used for operand magnitude and result correction.

Verification
REQ-032 SHALL check: mult srcA=0xFFFFFFFE, srcB=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done exactly 34 cycles after the start cycle, busy high for 33 cycles.
REQ-033 SHALL check: multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a start during busy is ignored.
REQ-034 SHALL check: div srcA=0xFFFFFFF9 (-7), srcB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; and 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 SHALL check: divu srcA=100, srcB=0 -> lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1 for exactly the done cycle.
REQ-036 SHALL check: flush at the 10th busy cycle -> busy=0 next cycle, no done, hi/lo keep prior values; rst mid-CALC -> hi=lo=0, IDLE.
REQ-037 SHALL check: build without MULDIV_DIV_EN, start with op=10 -> busy stays 0, no done within 40 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, iteration count and op-decode helpers.
package muldiv_pkg;

  localparam int unsigned MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10
  } muldiv_state_e;

  function automatic logic op_is_signed(input muldiv_op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

  function automatic logic op_is_div(input muldiv_op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement: passes din through, or negates it when neg=1.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: 32 shift-add or restoring steps, then
// one sign-correction cycle. Divide ops exist only with MULDIV_DIV_EN defined.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_by_zero
);

  muldiv_state_e       state, state_nxt;
  muldiv_op_e          op_in;
  logic [5:0]          cnt;
  logic [DATA_W-1:0]   acc_hi, acc_lo, opnd;
  logic [DATA_W-1:0]   a_mag, b_mag, load_opnd, load_lo;
  logic [DATA_W-1:0]   step_hi, step_lo, res_hi, res_lo;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_fix;
  logic                a_neg, b_neg, neg_lo, op_ok, accept;

  assign op_in  = muldiv_op_e'(op);
  assign a_neg  = op_is_signed(op_in) & srcA[DATA_W-1];
  assign b_neg  = op_is_signed(op_in) & srcB[DATA_W-1];
  assign accept = (state == ST_IDLE) && start && !flush && op_ok;
  assign busy   = (state != ST_IDLE);

  muldiv_signfix #(.W(DATA_W)) u_fix_a (.neg(a_neg), .din(srcA), .dout(a_mag));
  muldiv_signfix #(.W(DATA_W)) u_fix_b (.neg(b_neg), .din(srcB), .dout(b_mag));
  muldiv_signfix #(.W(2*DATA_W)) u_fix_prod (
    .neg(neg_lo), .din({acc_hi, acc_lo}), .dout(prod_fix)
  );

  // Multiply: {acc_hi,acc_lo} starts as {0,multiplier}; add multiplicand on LSB, shift right.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

`ifdef MULDIV_DIV_EN
  logic              is_div, neg_hi, bzero, dbz;
  logic [DATA_W:0]   div_shift;
  logic              div_ge;
  logic [DATA_W-1:0] quo_fix, rem_fix;

  assign op_ok = 1'b1;

  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd});

  muldiv_signfix #(.W(DATA_W)) u_fix_quo (.neg(neg_lo), .din(acc_lo), .dout(quo_fix));
  muldiv_signfix #(.W(DATA_W)) u_fix_rem (.neg(neg_hi), .din(acc_hi), .dout(rem_fix));

  always_comb begin
    load_opnd = a_mag;
    load_lo   = b_mag;
    if (op_is_div(op_in)) begin
      load_opnd = b_mag;
      load_lo   = a_mag;
    end
  end

  always_comb begin
    step_hi = mul_sum[DATA_W:1];
    step_lo = {mul_sum[0], acc_lo[DATA_W-1:1]};
    res_hi  = prod_fix[2*DATA_W-1:DATA_W];
    res_lo  = prod_fix[DATA_W-1:0];
    if (is_div) begin
      step_hi = div_ge ? (div_shift[DATA_W-1:0] - opnd) : div_shift[DATA_W-1:0];
      step_lo = {acc_lo[DATA_W-2:0], div_ge};
      // A zero divisor leaves the dividend in the remainder; only the quotient is forced.
      res_hi  = rem_fix;
      res_lo  = bzero ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      bzero  <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      dbz <= (state == ST_SIGN) && !flush && is_div && bzero;
      if (accept) begin
        is_div <= op_is_div(op_in);
        neg_hi <= a_neg;
        bzero  <= (srcB == '0);
      end
    end
  end

  assign div_by_zero = dbz;
`else
  assign op_ok       = !op_is_div(op_in);
  assign load_opnd   = a_mag;
  assign load_lo     = b_mag;
  assign step_hi     = mul_sum[DATA_W:1];
  assign step_lo     = {mul_sum[0], acc_lo[DATA_W-1:1]};
  assign res_hi      = prod_fix[2*DATA_W-1:DATA_W];
  assign res_lo      = prod_fix[DATA_W-1:0];
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) state_nxt = ST_CALC;
        ST_CALC: if (cnt == 6'(MULDIV_ITERS - 1)) state_nxt = ST_SIGN;
        ST_SIGN: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        cnt    <= '0;
        acc_hi <= '0;
        acc_lo <= load_lo;
        opnd   <= load_opnd;
        neg_lo <= a_neg ^ b_neg;
      end else if (state == ST_CALC && !flush) begin
        cnt    <= cnt + 6'd1;
        acc_hi <= step_hi;
        acc_lo <= step_lo;
      end else if (state == ST_SIGN && !flush) begin
        hi   <= res_hi;
        lo   <= res_lo;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: cycle-level reference model plus hand-computed
// result, latency and flush/reset expectations.
module tb_muldiv_unit;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  muldiv_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .div_by_zero(div_by_zero)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Result of an op from plain arithmetic: {div_by_zero, hi, lo}.
  function automatic logic [64:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin q = sa * sb; p = q; return {1'b0, p}; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'b0, a} / {32'b0, b});
          r = longint'({32'b0, a} % {32'b0, b});
        end
        qv = q;
        rv = r;
        return {1'b0, rv[31:0], qv[31:0]};
      end
    endcase
  endfunction

  // Reference model: an accepted op completes 33 edges later unless flushed or reset.
  int          m_left = 0;
  logic        m_done = 1'b0, m_dbz = 1'b0, p_dbz = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_dbz = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_left != 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz; m_done = 1'b1;
          end
        end
      end else if (start && !flush && (DIV_EN || !op[1])) begin
        {p_dbz, p_hi, p_lo} = model_res(op, srcA, srcB);
        m_left = 33;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_left != 0));
      check("done", 64'(done), 64'(m_done));
      check("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  // Issues one op at a negedge, optionally re-pokes start while busy; returns
  // negedges until done and the number of those with busy high.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, output int lat, output int bcnt);
    start = 1'b1; op = o; srcA = a; srcB = b;
    lat = 0; bcnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (lat == poke_at) begin
        start = 1'b1; op = 2'b00; srcA = 32'd5; srcB = 32'd5;
      end
      if (busy) bcnt++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int poke_at,
                         input logic [31:0] e_hi, input logic [31:0] e_lo);
    int lat, bcnt;
    run_op(o, a, b, poke_at, lat, bcnt);
    check({name, "_latency"}, 64'(lat), 64'd34);
    check({name, "_busy_cycles"}, 64'(bcnt), 64'd33);
    check({name, "_hi"}, 64'(hi), 64'(e_hi));
    check({name, "_lo"}, 64'(lo), 64'(e_lo));
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_lit("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_lit("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    // Started in the done cycle of the previous op.
    run_lit("mult_b2b", 2'b00, 32'd7, 32'hFFFF_FFFD, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

`ifdef MULDIV_DIV_EN
    run_lit("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_lit("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0, 32'h8000_0000);
    check("div_ovf_flag", 64'(div_by_zero), 64'd0);
    run_lit("divu_7", 2'b11, 32'd100, 32'd7, 0, 32'd2, 32'd14);
    run_lit("div_negdivisor", 2'b10, 32'd7, 32'hFFFF_FFFE, 0, 32'd1, 32'hFFFF_FFFD);
    run_lit("divu_zero", 2'b11, 32'd100, 32'd0, 0, 32'h0000_0064, 32'hFFFF_FFFF);
    check("divu_zero_flag", 64'(div_by_zero), 64'd1);
    @(negedge clk);
    check("divu_zero_flag_clear", 64'(div_by_zero), 64'd0);
    run_lit("div_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    check("div_zero_neg_flag", 64'(div_by_zero), 64'd1);
`else
    start = 1'b1; op = 2'b10; srcA = 32'd100; srcB = 32'd3;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done) seen = 1'b1;
    end
    check("nodiv_ignored", 64'(seen), 64'd0);
    check("nodiv_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
`endif

    // Flush during the 10th busy cycle.
    start = 1'b1; op = 2'b00; srcA = 32'd9; srcB = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'd0);
`ifdef MULDIV_DIV_EN
    check("flush_hilo", {hi, lo}, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
`else
    check("flush_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
`endif

    // Start together with flush while idle must not be accepted.
    start = 1'b1; flush = 1'b1; op = 2'b01; srcA = 32'd3; srcB = 32'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'd0);

    // Reset in the middle of CALC.
    start = 1'b1; op = 2'b01; srcA = 32'd123; srcB = 32'd456;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    run_lit("multu_after_rst", 2'b01, 32'h1234_5678, 32'd16, 0, 32'h0000_0001, 32'h2345_6780);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
